// File: rtl/window_if.sv
// Pixel stream bundle for the sliding-window generator.
// The master drives pixel columns in and receives windows back.
// The slave is the window generator itself.
interface window_if #(
  parameter int HEIGHT_NB = 3,
  parameter int WIDTH_NB  = 3,
  parameter int IMG_WIDTH = 8
);
  logic [IMG_WIDTH*HEIGHT_NB-1:0]          up_data;
  logic                                    up_val;
  logic [IMG_WIDTH*HEIGHT_NB*WIDTH_NB-1:0] win_data;
  logic                                    win_val;
  logic                                    win_last;

  modport master (
    output up_data, up_val,
    input  win_data, win_val, win_last
  );

  modport slave (
    input  up_data, up_val,
    output win_data, win_val, win_last
  );
endinterface

// File: rtl/window.sv
// Sliding-window generator.
// Pixel columns are shifted into a WIDTH_NB-deep column register, so the
// whole register is the current window. Column and row counters track the
// position in the frame. A window is flagged valid only when it lies fully
// inside the image. Because of that column gating, windows that straddle a
// row boundary are suppressed without flushing the shift register.
module window #(
  parameter int HEIGHT_NB  = 3,
  parameter int WIDTH_NB   = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_AWIDTH-1:0] cfg_width,
  input  logic [MEM_AWIDTH-1:0] cfg_height,
  input  logic                  cfg_set,
  window_if.slave               bus
);

  localparam int COL_W = IMG_WIDTH * HEIGHT_NB;
  localparam int WIN_W = COL_W * WIDTH_NB;

  localparam logic [MEM_AWIDTH-1:0] ZERO    = {MEM_AWIDTH{1'b0}};
  localparam logic [MEM_AWIDTH-1:0] ONE     = MEM_AWIDTH'(1);
  localparam logic [MEM_AWIDTH-1:0] MIN_COL = MEM_AWIDTH'(WIDTH_NB - 1);
  localparam logic [MEM_AWIDTH-1:0] MIN_ROW = MEM_AWIDTH'(HEIGHT_NB - 1);
  localparam logic [MEM_AWIDTH-1:0] NEED_W  = MEM_AWIDTH'(WIDTH_NB);
  localparam logic [MEM_AWIDTH-1:0] NEED_H  = MEM_AWIDTH'(HEIGHT_NB);

  logic [MEM_AWIDTH-1:0] cfg_width_r;
  logic [MEM_AWIDTH-1:0] cfg_height_r;
  logic [MEM_AWIDTH-1:0] col_r;
  logic [MEM_AWIDTH-1:0] row_r;
  logic [WIN_W-1:0]      win_r;
  logic                  win_val_r;
  logic                  win_last_r;

  logic [MEM_AWIDTH-1:0] last_col_s;
  logic [MEM_AWIDTH-1:0] last_row_s;
  logic                  col_end_s;
  logic                  row_end_s;
  logic                  dims_ok_s;
  logic                  fire_s;
  logic [WIN_W-1:0]      shifted_s;

  // Frame-position decode and next shift-register image.
  // A zero dimension wraps like a dimension of one.
  always_comb begin
    last_col_s = (cfg_width_r  == ZERO) ? ZERO : (cfg_width_r  - ONE);
    last_row_s = (cfg_height_r == ZERO) ? ZERO : (cfg_height_r - ONE);
    col_end_s  = (col_r == last_col_s);
    row_end_s  = (row_r == last_row_s);
    // The explicit size gate also covers zero-sized frames when
    // WIDTH_NB or HEIGHT_NB is 1.
    dims_ok_s  = (cfg_width_r >= NEED_W) && (cfg_height_r >= NEED_H);
    fire_s     = dims_ok_s && (col_r >= MIN_COL) && (row_r >= MIN_ROW);
    shifted_s  = win_r << COL_W;
    shifted_s[COL_W-1:0] = bus.up_data;
  end

  // Config latch, frame counters, column shift register and output flags.
  // cfg_set wins over a simultaneous column, which is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_width_r  <= ZERO;
      cfg_height_r <= ZERO;
      col_r        <= ZERO;
      row_r        <= ZERO;
      win_r        <= {WIN_W{1'b0}};
      win_val_r    <= 1'b0;
      win_last_r   <= 1'b0;
    end else if (cfg_set) begin
      cfg_width_r  <= cfg_width;
      cfg_height_r <= cfg_height;
      col_r        <= ZERO;
      row_r        <= ZERO;
      win_val_r    <= 1'b0;
      win_last_r   <= 1'b0;
    end else if (bus.up_val) begin
      win_r      <= shifted_s;
      win_val_r  <= fire_s;
      win_last_r <= fire_s && col_end_s && row_end_s;
      if (col_end_s) begin
        col_r <= ZERO;
        row_r <= row_end_s ? ZERO : (row_r + ONE);
      end else begin
        col_r <= col_r + ONE;
      end
    end else begin
      win_val_r  <= 1'b0;
      win_last_r <= 1'b0;
    end
  end

  assign bus.win_data = win_r;
  assign bus.win_val  = win_val_r;
  assign bus.win_last = win_last_r;

endmodule

// File: tb/tb_window.sv
// Bench for the sliding-window generator.
// It starts with a directed 5x4 frame applied from a vector table. Then come
// hand-written sequences for idle gaps, cfg_set collision, a narrow frame and
// asynchronous reset. It finishes with random traffic checked against a
// position/history reference model.
module tb_window;

  localparam int H  = 3;
  localparam int W  = 3;
  localparam int IW = 8;
  localparam int AW = 16;
  localparam int CW = IW * H;
  localparam int WW = CW * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_width;
  logic [AW-1:0] cfg_height;
  logic          cfg_set;

  window_if #(.HEIGHT_NB(H), .WIDTH_NB(W), .IMG_WIDTH(IW)) bus ();

  window #(.HEIGHT_NB(H), .WIDTH_NB(W), .IMG_WIDTH(IW), .MEM_AWIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .cfg_set   (cfg_set),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // reference model: the last W accepted columns (newest first), the
  // latched frame size, and the count of columns accepted since cfg_set
  logic [CW-1:0] hist[$];
  int   m_w = 0, m_h = 0, m_n = 0;
  logic m_val = 1'b0, m_last = 1'b0;

  typedef struct {
    logic          cs;
    int            cw;
    int            ch;
    logic          uv;
    logic [CW-1:0] d;
    logic          ev;
    logic          el;
    logic [WW-1:0] ed;
  } vec_t;

  vec_t tbl[21];
  int   pulse_idx[6] = '{12, 13, 14, 17, 18, 19};

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [WW-1:0] exp_win();
    logic [WW-1:0] r;
    r = '0;
    for (int w = 0; w < W; w++)
      if (w < hist.size()) r[w*CW +: CW] = hist[w];
    return r;
  endfunction

  // drive one cycle of inputs, let the edge happen, advance the model
  task automatic apply(input logic cs, input int cw, input int ch,
                       input logic uv, input logic [CW-1:0] d);
    int ew, eh, c, r;
    cfg_set     = cs;
    cfg_width   = AW'(cw);
    cfg_height  = AW'(ch);
    bus.up_val  = uv;
    bus.up_data = d;
    @(posedge clk);
    #1;
    if (cs) begin
      m_w = cw; m_h = ch; m_n = 0; m_val = 1'b0; m_last = 1'b0;
    end else if (uv) begin
      ew = (m_w == 0) ? 1 : m_w;
      eh = (m_h == 0) ? 1 : m_h;
      c  = m_n % ew;
      r  = (m_n / ew) % eh;
      hist.push_front(d);
      if (hist.size() > W) void'(hist.pop_back());
      m_val  = (m_w >= W) && (m_h >= H) && (c >= W - 1) && (r >= H - 1);
      m_last = m_val && (c == ew - 1) && (r == eh - 1);
      m_n++;
    end else begin
      m_val = 1'b0; m_last = 1'b0;
    end
    cfg_set    = 1'b0;
    bus.up_val = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_val"},  WW'(bus.win_val),  WW'(m_val));
    chk({tag, "_last"}, WW'(bus.win_last), WW'(m_last));
    chk({tag, "_data"}, bus.win_data,      exp_win());
  endtask

  // called just after a rising edge; asserts reset between edges
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_data", bus.win_data,      '0);
    chk("arst_val",  WW'(bus.win_val),  '0);
    chk("arst_last", WW'(bus.win_last), '0);
    hist.delete();
    m_w = 0; m_h = 0; m_n = 0; m_val = 1'b0; m_last = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int pulses, lasts, gaps, r;
    rst = 1'b0; cfg_set = 1'b0; cfg_width = '0; cfg_height = '0;
    bus.up_val = 1'b0; bus.up_data = '0;

    // vector table: 5x4 frame, columns valued by index
    tbl[0].cs = 1'b1; tbl[0].cw = 5; tbl[0].ch = 4; tbl[0].uv = 1'b0; tbl[0].d = '0;
    tbl[0].ev = 1'b0; tbl[0].el = 1'b0; tbl[0].ed = '0;
    for (int i = 0; i < 20; i++) begin
      tbl[i+1].cs = 1'b0; tbl[i+1].cw = 5; tbl[i+1].ch = 4; tbl[i+1].uv = 1'b1;
      tbl[i+1].d  = {3{8'(i)}};
      tbl[i+1].ev = 1'b0;
      tbl[i+1].el = (i == 19);
      tbl[i+1].ed = '0;
      for (int w = 0; w < W; w++)
        if (i - w >= 0) tbl[i+1].ed[w*CW +: CW] = {3{8'(i - w)}};
    end
    foreach (pulse_idx[k]) tbl[pulse_idx[k] + 1].ev = 1'b1;

    #1;
    chk("rst_data", bus.win_data,      '0);
    chk("rst_val",  WW'(bus.win_val),  '0);
    chk("rst_last", WW'(bus.win_last), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // back-to-back frame from the table
    pulses = 0; lasts = 0;
    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].cs, tbl[i].cw, tbl[i].ch, tbl[i].uv, tbl[i].d);
      chk($sformatf("tbl%0d_val", i),  WW'(bus.win_val),  WW'(tbl[i].ev));
      chk($sformatf("tbl%0d_last", i), WW'(bus.win_last), WW'(tbl[i].el));
      chk($sformatf("tbl%0d_data", i), bus.win_data,      tbl[i].ed);
      if (bus.win_val)  pulses++;
      if (bus.win_last) lasts++;
    end
    chk("tbl_pulses", WW'(pulses), WW'(6));
    chk("tbl_lasts",  WW'(lasts),  WW'(1));

    // same frame with 1-3 idle cycles between columns
    apply(1'b1, 5, 4, 1'b0, '0);
    check_model("gap_cfg");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 5, 4, 1'b1, {3{8'(i)}});
      check_model("gap_col");
      chk("gap_val_tbl", WW'(bus.win_val), WW'(tbl[i+1].ev));
      if (tbl[i+1].ev) chk("gap_data_tbl", bus.win_data, tbl[i+1].ed);
      if (bus.win_val) pulses++;
      gaps = $urandom_range(1, 3);
      for (int g = 0; g < gaps; g++) begin
        apply(1'b0, 5, 4, 1'b0, '0);
        chk("gap_idle_val", WW'(bus.win_val), '0);
      end
    end
    chk("gap_pulses", WW'(pulses), WW'(6));

    // cfg_set collides with a column at col 3, row 2
    apply(1'b1, 5, 4, 1'b0, '0);
    for (int i = 0; i < 13; i++) begin
      apply(1'b0, 5, 4, 1'b1, {3{8'(i)}});
      check_model("col_pre");
    end
    apply(1'b1, 5, 4, 1'b1, 24'hEEEEEE);
    check_model("col_set");
    chk("col_set_val",  WW'(bus.win_val), '0);
    chk("col_set_data", bus.win_data,     tbl[13].ed);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 5, 4, 1'b1, {3{8'(8'h40 + i)}});
      check_model("col_post");
      if (bus.win_val) pulses++;
    end
    chk("col_post_pulses", WW'(pulses), '0);
    apply(1'b0, 5, 4, 1'b1, 24'h4C4C4C);
    check_model("col_first");
    chk("col_first_val", WW'(bus.win_val), WW'(1));

    // frame narrower than the window
    apply(1'b1, 2, 10, 1'b0, '0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      apply(1'b0, 2, 10, 1'b1, 24'($urandom));
      check_model("narrow");
      if (bus.win_val) pulses++;
    end
    chk("narrow_pulses", WW'(pulses), '0);

    // asynchronous reset mid-frame, right after a valid window
    apply(1'b1, 5, 4, 1'b0, '0);
    for (int i = 0; i < 14; i++) apply(1'b0, 5, 4, 1'b1, {3{8'(8'h80 + i)}});
    chk("pre_arst_val", WW'(bus.win_val), WW'(1));
    async_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 5, 4, 1'b1, {3{8'(8'h90 + i)}});
      check_model("post_arst");
      if (bus.win_val) pulses++;
    end
    chk("post_arst_pulses", WW'(pulses), '0);
    apply(1'b1, 5, 4, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 5, 4, 1'b1, 24'($urandom));
      check_model("recfg");
    end

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        apply(1'b1, $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 24'($urandom));
      end else if (r < 4) begin
        async_reset();
        apply(1'b1, $urandom_range(0, 7), $urandom_range(0, 7), 1'b0, '0);
      end else begin
        apply(1'b0, 0, 0, ($urandom_range(0, 3) != 0), 24'($urandom));
      end
      check_model("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
